// File: rtl/button_shaper_pkg.sv
// Shared types and helpers for the multi-channel push-button conditioner.
// Optional feature macro: BUTTON_SHAPER_MULTI_REPEAT_EN (hold-to-repeat pulses).
package button_shaper_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 3'd0,
    PRESS_DB = 3'd1,
    PULSE    = 3'd2,
    HELD     = 3'd3,
    REL_DB   = 3'd4,
    REPEAT   = 3'd5
  } chan_state_e;

  // Wide enough to hold the largest terminal count without wrapping.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/button_shaper_multi_if.sv
// Button-side bundle: raw active-low buttons in, shaped pulse/held flags out.
// Optional feature macro: BUTTON_SHAPER_MULTI_REPEAT_EN (no effect on this bundle).
interface button_shaper_multi_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] button_in;
  logic [N_BTN-1:0] pulse_out;
  logic [N_BTN-1:0] held_out;
  logic             any_pulse;

  modport master (output button_in, input pulse_out, held_out, any_pulse);
  modport slave  (input button_in, output pulse_out, held_out, any_pulse);
endinterface

// File: rtl/button_shaper_chan.sv
// One button channel: 2-flop synchroniser, debounce FSM and counters.
// Macro BUTTON_SHAPER_MULTI_REPEAT_EN adds the REPEAT state with delay/period counting.
module button_shaper_chan
  import button_shaper_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 1000,
  parameter int REPEAT_PERIOD   = 250
) (
  input  logic clk,
  input  logic rst,
  input  logic button_in,
  output logic pulse_out,
  output logic held_out
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic sync_p0, sync_p1;
  chan_state_e state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

`ifdef BUTTON_SHAPER_MULTI_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  logic [CNT_W-1:0] rpt_cnt, rpt_nxt;
  logic first, first_nxt;
`endif

  // Stage p0/p1: synchroniser, idles at released (1)
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= button_in;
      sync_p1 <= sync_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
`ifdef BUTTON_SHAPER_MULTI_REPEAT_EN
      rpt_cnt <= '0;
      first   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
`ifdef BUTTON_SHAPER_MULTI_REPEAT_EN
      rpt_cnt <= rpt_nxt;
      first   <= first_nxt;
`endif
    end
  end

  // Moore outputs depend on state only; unused encodings fall back to IDLE
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pulse_out = 1'b0;
    held_out  = 1'b0;
`ifdef BUTTON_SHAPER_MULTI_REPEAT_EN
    rpt_nxt   = rpt_cnt;
    first_nxt = first;
`endif
    case (state)
      IDLE: begin
        if (!sync_p1) begin
          state_nxt = PRESS_DB;
          cnt_nxt   = '0;
        end
      end
      PRESS_DB: begin
        if (sync_p1)             state_nxt = IDLE;
        else if (cnt == DB_LAST) state_nxt = PULSE;
        else                     cnt_nxt   = cnt + CNT_W'(1);
      end
      PULSE: begin
        pulse_out = 1'b1;
        held_out  = 1'b1;
        state_nxt = HELD;
`ifdef BUTTON_SHAPER_MULTI_REPEAT_EN
        rpt_nxt   = '0;
        first_nxt = 1'b1;
`endif
      end
      HELD: begin
        held_out = 1'b1;
        if (sync_p1) begin
          state_nxt = REL_DB;
          cnt_nxt   = '0;
        end
`ifdef BUTTON_SHAPER_MULTI_REPEAT_EN
        else if (rpt_cnt == (first ? RPT_DELAY_LAST : RPT_PERIOD_LAST)) state_nxt = REPEAT;
        else rpt_nxt = rpt_cnt + CNT_W'(1);
`endif
      end
      REL_DB: begin
        held_out = 1'b1;
        if (!sync_p1) begin
          state_nxt = HELD;
`ifdef BUTTON_SHAPER_MULTI_REPEAT_EN
          rpt_nxt   = '0;
`endif
        end else if (cnt == DB_LAST) state_nxt = IDLE;
        else                         cnt_nxt   = cnt + CNT_W'(1);
      end
`ifdef BUTTON_SHAPER_MULTI_REPEAT_EN
      REPEAT: begin
        pulse_out = 1'b1;
        held_out  = 1'b1;
        state_nxt = HELD;
        rpt_nxt   = '0;
        first_nxt = 1'b0;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/button_shaper_multi.sv
// N-channel push-button conditioner: independent shaper per button plus an any-pulse OR.
// Macro BUTTON_SHAPER_MULTI_REPEAT_EN enables hold-to-repeat pulses in every channel.
module button_shaper_multi
  import button_shaper_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 1000,
  parameter int REPEAT_PERIOD   = 250
) (
  input logic                 clk,
  input logic                 rst,
  button_shaper_multi_if.slave bus
);

  logic [N_BTN-1:0] pulse_vec;
  logic [N_BTN-1:0] held_vec;

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    button_shaper_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .button_in(bus.button_in[i]),
      .pulse_out(pulse_vec[i]),
      .held_out (held_vec[i])
    );
  end

  assign bus.pulse_out = pulse_vec;
  assign bus.held_out  = held_vec;
  assign bus.any_pulse = |pulse_vec;

endmodule

// File: tb/tb_button_shaper_multi.sv
// Scoreboard bench for button_shaper_multi (N_BTN=4, DEBOUNCE_CYCLES=4, REPEAT 20/8).
// Build with BUTTON_SHAPER_MULTI_REPEAT_EN defined to also cover hold-to-repeat.
module tb_button_shaper_multi;

  localparam int BIG = 1 << 30;

  typedef struct {
    int         cyc;
    logic [3:0] vec;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  ev_t  sb[$];
  int   hon[4];
  int   hoff[4];

  button_shaper_multi_if #(.N_BTN(4)) bus ();

  button_shaper_multi #(
    .N_BTN(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [3:0] v);
    ev_t e;
    e.cyc = c;
    e.vec = v;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    bus.button_in = 4'hF;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin hon[c] = 0; hoff[c] = 0; end
    repeat (3) step();
    n_cmp++; if (bus.pulse_out !== 4'h0) begin n_err++; $display("FAIL reset pulse_out got=%b exp=0000", bus.pulse_out); end
    n_cmp++; if (bus.held_out !== 4'h0) begin n_err++; $display("FAIL reset held_out got=%b exp=0000", bus.held_out); end
    n_cmp++; if (bus.any_pulse !== 1'b0) begin n_err++; $display("FAIL reset any_pulse got=%b exp=0", bus.any_pulse); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_single_press();
    ev_t e; logic [3:0] ep, eh; int p;
    p = 0;
    for (int i = 0; i < 70; i++) begin
      if (i == 0) begin
        bus.button_in[0] = 1'b0; p = cyc + 7;
        push(p, 4'b0001);
`ifdef BUTTON_SHAPER_MULTI_REPEAT_EN
        push(p + 21, 4'b0001); push(p + 30, 4'b0001); push(p + 39, 4'b0001); push(p + 48, 4'b0001);
`endif
        hon[0] = p; hoff[0] = BIG;
      end
      if (i == 57) begin bus.button_in[0] = 1'b1; hoff[0] = cyc + 7; end
      step();
      ep = '0;
      if (sb.size() != 0 && sb[0].cyc == cyc) begin e = sb.pop_front(); ep = e.vec; end
      for (int c = 0; c < 4; c++) eh[c] = (cyc >= hon[c] && cyc < hoff[c]);
      n_cmp++; if (bus.pulse_out !== ep) begin n_err++; $display("FAIL single cyc=%0d pulse_out got=%b exp=%b", cyc, bus.pulse_out, ep); end
      n_cmp++; if (bus.held_out !== eh) begin n_err++; $display("FAIL single cyc=%0d held_out got=%b exp=%b", cyc, bus.held_out, eh); end
      n_cmp++; if (bus.any_pulse !== (|ep)) begin n_err++; $display("FAIL single cyc=%0d any_pulse got=%b exp=%b", cyc, bus.any_pulse, |ep); end
    end
  endtask

  task automatic test_glitch();
    ev_t e; logic [3:0] ep, eh;
    for (int i = 0; i < 15; i++) begin
      if (i == 0) bus.button_in[1] = 1'b0;
      if (i == 3) bus.button_in[1] = 1'b1;
      step();
      ep = '0;
      if (sb.size() != 0 && sb[0].cyc == cyc) begin e = sb.pop_front(); ep = e.vec; end
      for (int c = 0; c < 4; c++) eh[c] = (cyc >= hon[c] && cyc < hoff[c]);
      n_cmp++; if (bus.pulse_out !== ep) begin n_err++; $display("FAIL glitch cyc=%0d pulse_out got=%b exp=%b", cyc, bus.pulse_out, ep); end
      n_cmp++; if (bus.held_out !== eh) begin n_err++; $display("FAIL glitch cyc=%0d held_out got=%b exp=%b", cyc, bus.held_out, eh); end
    end
  endtask

  task automatic test_simultaneous();
    ev_t e; logic [3:0] ep, eh;
    for (int i = 0; i < 28; i++) begin
      if (i == 0) begin
        bus.button_in[0] = 1'b0; bus.button_in[2] = 1'b0;
        push(cyc + 7, 4'b0101);
        hon[0] = cyc + 7; hon[2] = cyc + 7; hoff[0] = BIG; hoff[2] = BIG;
      end
      if (i == 15) begin
        bus.button_in[0] = 1'b1; bus.button_in[2] = 1'b1;
        hoff[0] = cyc + 7; hoff[2] = cyc + 7;
      end
      step();
      ep = '0;
      if (sb.size() != 0 && sb[0].cyc == cyc) begin e = sb.pop_front(); ep = e.vec; end
      for (int c = 0; c < 4; c++) eh[c] = (cyc >= hon[c] && cyc < hoff[c]);
      n_cmp++; if (bus.pulse_out !== ep) begin n_err++; $display("FAIL simul cyc=%0d pulse_out got=%b exp=%b", cyc, bus.pulse_out, ep); end
      n_cmp++; if (bus.held_out !== eh) begin n_err++; $display("FAIL simul cyc=%0d held_out got=%b exp=%b", cyc, bus.held_out, eh); end
      n_cmp++; if (bus.any_pulse !== (|ep)) begin n_err++; $display("FAIL simul cyc=%0d any_pulse got=%b exp=%b", cyc, bus.any_pulse, |ep); end
    end
  endtask

  task automatic test_release_bounce();
    ev_t e; logic [3:0] ep, eh;
    for (int i = 0; i < 42; i++) begin
      if (i == 0) begin
        bus.button_in[3] = 1'b0; push(cyc + 7, 4'b1000);
        hon[3] = cyc + 7; hoff[3] = BIG;
      end
      if (i == 12) bus.button_in[3] = 1'b1;
      if (i == 14) bus.button_in[3] = 1'b0;
      if (i == 30) begin bus.button_in[3] = 1'b1; hoff[3] = cyc + 7; end
      step();
      ep = '0;
      if (sb.size() != 0 && sb[0].cyc == cyc) begin e = sb.pop_front(); ep = e.vec; end
      for (int c = 0; c < 4; c++) eh[c] = (cyc >= hon[c] && cyc < hoff[c]);
      n_cmp++; if (bus.pulse_out !== ep) begin n_err++; $display("FAIL bounce cyc=%0d pulse_out got=%b exp=%b", cyc, bus.pulse_out, ep); end
      n_cmp++; if (bus.held_out !== eh) begin n_err++; $display("FAIL bounce cyc=%0d held_out got=%b exp=%b", cyc, bus.held_out, eh); end
    end
  endtask

  task automatic test_reset_mid_press();
    ev_t e; logic [3:0] ep, eh;
    for (int i = 0; i < 38; i++) begin
      if (i == 0) bus.button_in[0] = 1'b0;
      if (i == 4) rst = 1'b0;
      if (i == 5) begin
        rst = 1'b1; push(cyc + 7, 4'b0001);
        hon[0] = cyc + 7; hoff[0] = BIG;
      end
      if (i == 25) begin bus.button_in[0] = 1'b1; hoff[0] = cyc + 7; end
      step();
      ep = '0;
      if (sb.size() != 0 && sb[0].cyc == cyc) begin e = sb.pop_front(); ep = e.vec; end
      for (int c = 0; c < 4; c++) eh[c] = (cyc >= hon[c] && cyc < hoff[c]);
      n_cmp++; if (bus.pulse_out !== ep) begin n_err++; $display("FAIL rst_mid cyc=%0d pulse_out got=%b exp=%b", cyc, bus.pulse_out, ep); end
      n_cmp++; if (bus.held_out !== eh) begin n_err++; $display("FAIL rst_mid cyc=%0d held_out got=%b exp=%b", cyc, bus.held_out, eh); end
      n_cmp++; if (bus.any_pulse !== (|ep)) begin n_err++; $display("FAIL rst_mid cyc=%0d any_pulse got=%b exp=%b", cyc, bus.any_pulse, |ep); end
    end
  endtask

`ifdef BUTTON_SHAPER_MULTI_REPEAT_EN
  task automatic test_repeat();
    ev_t e; logic [3:0] ep, eh; int p;
    p = 0;
    for (int i = 0; i < 80; i++) begin
      if (i == 0) begin
        bus.button_in[0] = 1'b0; p = cyc + 7;
        push(p, 4'b0001); push(p + 21, 4'b0001); push(p + 30, 4'b0001);
        push(p + 39, 4'b0001); push(p + 48, 4'b0001); push(p + 57, 4'b0001);
        hon[0] = p; hoff[0] = BIG;
      end
      if (i == 67) begin bus.button_in[0] = 1'b1; hoff[0] = cyc + 7; end
      step();
      ep = '0;
      if (sb.size() != 0 && sb[0].cyc == cyc) begin e = sb.pop_front(); ep = e.vec; end
      for (int c = 0; c < 4; c++) eh[c] = (cyc >= hon[c] && cyc < hoff[c]);
      n_cmp++; if (bus.pulse_out !== ep) begin n_err++; $display("FAIL repeat cyc=%0d pulse_out got=%b exp=%b", cyc, bus.pulse_out, ep); end
      n_cmp++; if (bus.held_out !== eh) begin n_err++; $display("FAIL repeat cyc=%0d held_out got=%b exp=%b", cyc, bus.held_out, eh); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_simultaneous();
    test_release_bounce();
    test_reset_mid_press();
`ifdef BUTTON_SHAPER_MULTI_REPEAT_EN
    test_repeat();
`endif
    n_cmp++;
    if (sb.size() !== 0) begin
      n_err++;
      $display("FAIL scoreboard_drain pending got=%0d exp=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
